// File: rtl/i2c_pkg.sv
// Shared constants for the I2C slave: FSM encodings, the general-call address
// and bus ACK/NACK levels.
package i2c_pkg;
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_PTR      = 4'd3;
  localparam logic [3:0] ST_PTR_ACK  = 4'd4;
  localparam logic [3:0] ST_WR       = 4'd5;
  localparam logic [3:0] ST_WR_ACK   = 4'd6;
  localparam logic [3:0] ST_RD       = 4'd7;
  localparam logic [3:0] ST_RD_ACK   = 4'd8;
  localparam logic [3:0] ST_IGNORE   = 4'd9;

  localparam logic [6:0] I2C_GENERAL_CALL = 7'd0;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
endpackage

// File: rtl/i2c_slave_core_if.sv
// Register-bank port of the I2C slave; the core is the master of this bus.
interface i2c_slave_core_if #(parameter int REG_AW = 8);
  logic [REG_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/i2c_sync_edge.sv
// Pad synchroniser plus edge register; idles high so reset never fakes an edge.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;
endmodule

// File: rtl/i2c_slave_core.sv
// Oversampling I2C slave with register pointer and byte-wide register port.
// Define I2C_SLAVE_AUTOINC_EN to post-increment the pointer after each access.
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ID    = 7'd2,
  parameter int         REG_AW      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic busy,
  i2c_slave_core_if.master mem
);
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .reset(reset), .d_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .reset(reset), .d_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  logic              start_det, stop_det;
  logic [3:0]        state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d, byte_in;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rw_q, rw_d, we_q, we_d, re_q, re_d;
  logic              ld_q, ld_d, drv_q, drv_d, oe_q, oe_d, busy_q, busy_d;
  // ph_q: second half of an ACK slot (first SCL fall inside it has passed)
  logic              ph_q, ph_d;

  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;
  assign byte_in   = {shift_q[6:0], sda_lvl};

  always_comb begin
    state_d = state_q;  bitcnt_d = bitcnt_q; shift_d = shift_q; ptr_d = ptr_q;
    wdata_d = wdata_q;  rw_d = rw_q;         oe_d = oe_q;       busy_d = busy_q;
    ph_d    = ph_q;     we_d = 1'b0;         re_d = 1'b0;       ld_d = re_q;
    drv_d   = 1'b0;
`ifdef I2C_SLAVE_AUTOINC_EN
    if (we_q || re_q) ptr_d = ptr_q + 1'b1;
`endif
    if (ld_q) begin
      shift_d = mem.mem_rdata;
      drv_d   = 1'b1;
    end
    if (drv_q) oe_d = ~shift_q[7];
    if (start_det || stop_det) begin
      state_d  = start_det ? ST_ADDR : ST_IDLE;
      busy_d   = start_det;
      bitcnt_d = 3'd0;
      oe_d     = 1'b0;
      ph_d     = 1'b0;
      ld_d     = 1'b0;
      drv_d    = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR: begin
          shift_d  = byte_in;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            ph_d = 1'b0;
            if (state_q == ST_ADDR) begin
              rw_d    = byte_in[0];
              state_d = (byte_in[7:1] == SLAVE_ID && byte_in[7:1] != I2C_GENERAL_CALL)
                        ? ST_ADDR_ACK : ST_IGNORE;
            end else if (state_q == ST_PTR) begin
              ptr_d   = byte_in[REG_AW-1:0];
              state_d = ST_PTR_ACK;
            end else begin
              wdata_d = byte_in;
              we_d    = 1'b1;
              state_d = ST_WR_ACK;
            end
          end
        end
        ST_RD: begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_RD_ACK;
            ph_d    = 1'b0;
          end
        end
        ST_RD_ACK: if (ph_q && sda_lvl == I2C_NACK) state_d = ST_IGNORE;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (!ph_q) begin
            oe_d = 1'b1;
            ph_d = 1'b1;
          end else begin
            oe_d     = 1'b0;
            bitcnt_d = 3'd0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d = ST_RD;
              re_d    = 1'b1;
            end else begin
              state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WR;
            end
          end
        end
        ST_RD: begin
          shift_d = {shift_q[6:0], 1'b0};
          oe_d    = ~shift_q[6];
        end
        ST_RD_ACK: begin
          if (!ph_q) begin
            oe_d = 1'b0;
            ph_d = 1'b1;
          end else begin
            re_d     = 1'b1;
            state_d  = ST_RD;
            bitcnt_d = 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE; bitcnt_q <= '0;  shift_q <= '0;  ptr_q  <= '0;
      wdata_q <= '0;      rw_q     <= 1'b0; we_q   <= 1'b0; re_q   <= 1'b0;
      ld_q    <= 1'b0;    drv_q    <= 1'b0; oe_q   <= 1'b0; busy_q <= 1'b0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d; bitcnt_q <= bitcnt_d; shift_q <= shift_d; ptr_q  <= ptr_d;
      wdata_q <= wdata_d; rw_q     <= rw_d;     we_q    <= we_d;    re_q   <= re_d;
      ld_q    <= ld_d;    drv_q    <= drv_d;    oe_q    <= oe_d;    busy_q <= busy_d;
      ph_q    <= ph_d;
    end
  end

  assign sda_oe        = oe_q;
  assign busy          = busy_q;
  assign mem.mem_addr  = ptr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_re    = re_q;
endmodule

// File: tb/tb_i2c_slave_core.sv
// Bit-banged I2C master against two slaves sharing one open-drain bus.
module tb_i2c_slave_core;
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif
  localparam int Q = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, scl, m_low, sda_bus;
  logic oe0, oe1, busy0, busy1;
  int   total = 0, bad = 0, oe0_cnt = 0;
  logic we0_prev = 1'b0, re0_prev = 1'b0, we1_prev = 1'b0;

  logic [15:0] weq0[$];
  logic [11:0] weq1[$];
  logic [7:0]  req0[$], rdq[$];

  assign sda_bus = ~(m_low | oe0 | oe1);

  i2c_slave_core_if #(.REG_AW(8)) m0 ();
  i2c_slave_core_if #(.REG_AW(4)) m1 ();
  assign m1.mem_rdata = 8'h00;

  i2c_slave_core #(.SLAVE_ID(7'd2), .REG_AW(8), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .scl_i(scl), .sda_i(sda_bus),
    .sda_oe(oe0), .busy(busy0), .mem(m0.master));
  i2c_slave_core #(.SLAVE_ID(7'h33), .REG_AW(4), .SYNC_STAGES(3)) dut1 (
    .clk(clk), .reset(reset), .scl_i(scl), .sda_i(sda_bus),
    .sda_oe(oe1), .busy(busy1), .mem(m1.master));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // register bank model: read data appears one clock after mem_re
  always @(posedge clk) begin
    if (reset) m0.mem_rdata <= 8'h00;
    else if (m0.mem_re) begin
      if (rdq.size() != 0) m0.mem_rdata <= rdq.pop_front();
      else m0.mem_rdata <= 8'h00;
    end
  end

  always @(negedge clk) begin
    if (oe0) oe0_cnt <= oe0_cnt + 1;
    if (m0.mem_we) begin
      chk("we0_pending", weq0.size() != 0, 1);
      if (weq0.size() != 0) chk("we0", {m0.mem_addr, m0.mem_wdata}, weq0.pop_front());
      chk("we0_width", we0_prev, 0);
    end
    if (m0.mem_re) begin
      chk("re0_pending", req0.size() != 0, 1);
      if (req0.size() != 0) chk("re0_addr", m0.mem_addr, req0.pop_front());
      chk("re0_width", re0_prev, 0);
    end
    if (m1.mem_we) begin
      chk("we1_pending", weq1.size() != 0, 1);
      if (weq1.size() != 0) chk("we1", {m1.mem_addr, m1.mem_wdata}, weq1.pop_front());
      chk("we1_width", we1_prev, 0);
    end
    if (m1.mem_re) chk("re1_unexp", m1.mem_re, 0);
    we0_prev <= m0.mem_we;
    re0_prev <= m0.mem_re;
    we1_prev <= m1.mem_we;
  end

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!scl) begin
      w(Q); m_low = 1'b0; w(Q); scl = 1'b1; w(2*Q);
    end
    m_low = 1'b1; w(2*Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    w(Q); m_low = 1'b1; w(Q); scl = 1'b1; w(2*Q); m_low = 1'b0; w(2*Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      w(Q); m_low = ~b[7-i]; w(Q); scl = 1'b1; w(2*Q); scl = 1'b0;
    end
  endtask

  task automatic write_byte(input string tag, input logic [7:0] b, input logic exp_ack);
    logic ack;
    write_bits(b, 8);
    w(Q); m_low = 1'b0; w(Q); scl = 1'b1; w(Q); ack = sda_bus; w(Q); scl = 1'b0;
    chk(tag, ack, exp_ack);
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp, input logic mack);
    logic [7:0] b;
    m_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w(2*Q); scl = 1'b1; w(Q); b[7-i] = sda_bus; w(Q); scl = 1'b0;
    end
    w(Q); m_low = mack; w(Q); scl = 1'b1; w(2*Q); scl = 1'b0; w(Q); m_low = 1'b0;
    chk(tag, b, exp);
  endtask

  initial begin
    int c0;
    reset = 1'b1; scl = 1'b1; m_low = 1'b0;
    w(5);
    chk("rst_oe0", oe0, 0);     chk("rst_busy0", busy0, 0);
    chk("rst_addr0", m0.mem_addr, 0); chk("rst_wdata0", m0.mem_wdata, 0);
    chk("rst_we0", m0.mem_we, 0); chk("rst_re0", m0.mem_re, 0);
    chk("rst_oe1", oe1, 0);
    reset = 1'b0; w(5);

    // write burst
    i2c_start(); w(Q);
    chk("wb_busy_hi", busy0, 1);
    write_byte("wb_ack_addr", 8'h04, 1'b0);
    write_byte("wb_ack_ptr", 8'h10, 1'b0);
    weq0.push_back({8'h10, 8'hA5});
    write_byte("wb_ack_d0", 8'hA5, 1'b0);
    weq0.push_back({AI ? 8'h11 : 8'h10, 8'h3C});
    write_byte("wb_ack_d1", 8'h3C, 1'b0);
    i2c_stop();
    chk("wb_busy_lo", busy0, 0);

    // random read through repeated START
    i2c_start();
    write_byte("rd_ack_addr", 8'h04, 1'b0);
    write_byte("rd_ack_ptr", 8'h20, 1'b0);
    i2c_start();
    req0.push_back(8'h20); rdq.push_back(8'h5A);
    req0.push_back(AI ? 8'h21 : 8'h20); rdq.push_back(8'hC3);
    write_byte("rd_ack_raddr", 8'h05, 1'b0);
    read_byte("rd_d0", 8'h5A, 1'b1);
    read_byte("rd_d1", 8'hC3, 1'b0);
    w(Q);
    chk("rd_release", oe0, 0);
    i2c_stop();
    chk("rd_busy_lo", busy0, 0);

    // wrong address and general call
    c0 = oe0_cnt;
    i2c_start();
    write_byte("wa_nack_addr", 8'h06, 1'b1);
    write_byte("wa_nack_data", 8'hFF, 1'b1);
    i2c_stop();
    i2c_start();
    write_byte("gc_nack", 8'h00, 1'b1);
    i2c_stop();
    chk("wa_oe_never", oe0_cnt - c0, 0);

    // abort mid-byte, then a clean transfer
    i2c_start();
    write_byte("ab_ack_addr", 8'h04, 1'b0);
    write_byte("ab_ack_ptr", 8'h10, 1'b0);
    write_bits(8'hA0, 4);
    i2c_stop();
    chk("ab_busy_lo", busy0, 0);
    i2c_start();
    write_byte("ab2_ack_addr", 8'h04, 1'b0);
    write_byte("ab2_ack_ptr", 8'h30, 1'b0);
    weq0.push_back({8'h30, 8'h77});
    write_byte("ab2_ack_d", 8'h77, 1'b0);
    i2c_stop();

    // pointer wrap on the 4-bit slave
    i2c_start();
    write_byte("wr_ack_addr", 8'h66, 1'b0);
    write_byte("wr_ack_ptr", 8'h0F, 1'b0);
    weq1.push_back({4'hF, 8'h11});
    write_byte("wr_ack_d0", 8'h11, 1'b0);
    weq1.push_back({AI ? 4'h0 : 4'hF, 8'h22});
    write_byte("wr_ack_d1", 8'h22, 1'b0);
    i2c_stop();

    // reset while driving the address ACK
    i2c_start();
    write_bits(8'h04, 8);
    for (int i = 0; i < 30 && !oe0; i++) w(1);
    chk("mr_oe_pre", oe0, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mr_oe", oe0, 0);       chk("mr_busy", busy0, 0);
    chk("mr_addr", m0.mem_addr, 0); chk("mr_wdata", m0.mem_wdata, 0);
    chk("mr_we", m0.mem_we, 0); chk("mr_re", m0.mem_re, 0);
    w(2); reset = 1'b0; m_low = 1'b0;
    w(Q); scl = 1'b1; w(4*Q);

    chk("end_weq0", weq0.size(), 0);
    chk("end_req0", req0.size(), 0);
    chk("end_weq1", weq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
